hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Next-gen hazard unit per core: replaces pure load-use/branch detection with a register scoreboard
//  for one multi-cycle unit (DIV/FDIV/FSQRT/AMO). Sits beside the decode/execute boundary.
//  Drives F/D stall, D/E flush and an E bubble. Handles NRF register files (0=int, 1=FP) and NSRC decode sources (rs1/rs2/rs3).
// PARAMETERS
//  NREG     32  registers per file; address width AW=$clog2(NREG)
//  NRF      2   register files; rf index width RW=$clog2(NRF); file 0 has hardwired x0
//  NSRC     3   decode source operands checked
//  TMO_W    8   width of busy watchdog counter; timeout at all-ones
//  PERF_W   32  width of saturating stall-cycle counter
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous, active-low reset
//  src_vld_d    in   NSRC        decode source i is read
//  src_rf_d     in   NSRC*RW     file of source i
//  src_ad_d     in   NSRC*AW     register of source i
//  dst_vld_d    in   1           decode insn writes a register
//  dst_rf_d     in   RW          its file
//  dst_ad_d     in   AW          its register
//  mc_req_d     in   1           decode insn needs the multi-cycle unit
//  ld_e         in   1           E-stage insn is a load (any file)
//  ld_rf_e      in   RW          load destination file
//  ld_rd_e      in   AW          load destination register
//  pcsrc_e      in   1           taken branch/jump resolved in E
//  mc_issue     in   1           multi-cycle op leaves E into unit this cycle
//  mc_issue_rf  in   RW          its destination file
//  mc_issue_rd  in   AW          its destination register
//  mc_done      in   1           unit writes back this cycle
//  stall_f      out  1           hold PC
//  stall_d      out  1           hold IF/ID
//  flush_d      out  1           clear IF/ID
//  flush_e      out  1           clear ID/EX (branch or bubble)
//  mc_busy      out  1           unit occupied
//  mc_tmo       out  1           sticky watchdog error
//  stall_cnt    out  PERF_W      stall cycles, saturating
// BEHAVIOUR
//  Reset (rst=0 at clk edge): scoreboard all 0, FSM IDLE, watchdog 0, mc_tmo 0, stall_cnt 0.
//  While rst=0 all combinational outputs forced 0.
//  Scoreboard sb[rf][reg]: set on mc_issue; cleared on mc_done for the recorded pending (rf,rd).
//  Same-cycle done+issue to the same reg: set wins. A write targeting rf0/reg0 is never recorded.
//  FP reg f0 is a real register and is tracked.
//  Hazards (combinational, 0-cycle):
//   raw   = any i: src_vld_d[i] & sb[src_rf][src_ad]
//   lduse = ld_e & any i: src matches (ld_rf_e,ld_rd_e), excluding rf0/reg0
//   waw   = dst_vld_d & sb[dst_rf][dst_ad]
//   strct = mc_req_d & mc_busy & !mc_done
//   hz    = raw|lduse|waw|strct
//  Outputs:
//   pcsrc_e=1: flush_d=flush_e=1, stall_f=stall_d=0 (branch beats any stall)
//   else hz=1: stall_f=stall_d=1, flush_e=1 (bubble), flush_d=0
//   else all 0
//  FSM: IDLE -mc_issue-> BUSY; BUSY -mc_done&!mc_issue-> IDLE; BUSY -mc_done&mc_issue-> BUSY (back-to-back).
//  mc_issue in BUSY without mc_done: ignored and mc_tmo set (protocol error). mc_done in IDLE: ignored.
//  Watchdog: cleared on entry to BUSY, increments each BUSY cycle; at all-ones sets mc_tmo, then holds.
//  mc_tmo clears only on reset. stall_cnt increments when stall_d=1; holds at all-ones.
//  Pending (rf,rd) is held in a register for clearing; only one op is outstanding.
// STRUCTURE
//  Package hazard_pkg: RF_INT=0/RF_FP=1 constants, mc_state_e {IDLE,BUSY}, function is_x0(rf,ad).
//  One sub-module, sb_regfile: NRF*NREG bit array with set/clear ports and NSRC+1 read ports.
//  The FSM, watchdog and hazard combine logic live in the top.
// TESTING
//  FDIV f0 issue (rf1,rd0), next decode fadd src f0 -> stall_d=1, flush_e=1 until mc_done; released the following cycle.
//  Load x0 in E, decode reads x0 -> no stall. Load x5 in E, decode rs2=x5 -> one-cycle stall plus bubble.
//  DIV x7 busy, decode mc_req_d=1 -> strct stall. mc_done and mc_issue x8 same cycle -> FSM stays BUSY, sb x7=0, x8=1.
//  Stall condition and pcsrc_e=1 together -> flush_d=flush_e=1, stall_f=0, stall_cnt unchanged.
//  BUSY held 255 cycles with TMO_W=8 -> mc_tmo=1 and stays set. Reset mid-BUSY -> sb cleared, FSM IDLE.
//  Decode dst x9 while x9 pending -> waw stall. Force stall_cnt to all-ones -> next stall holds the value.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: register-file ids, multi-cycle FSM state and
// the hardwired-zero test shared by the scoreboard hazard unit.
package hazard_pkg;

  localparam int unsigned RF_INT = 0;
  localparam int unsigned RF_FP  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_e;

  function automatic logic is_x0(
    input int unsigned rf,
    input int unsigned ad
  );
    return (rf == RF_INT) && (ad == 0);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_regfile.sv
// sb_regfile: one pending bit per architectural register,
// with a set and a clear port and NSRC+1 combinational reads.
module sb_regfile
  import hazard_pkg::*;
#(
  parameter  int NREG = 32,
  parameter  int NRF  = 2,
  parameter  int NSRC = 3,
  localparam int AW   = $clog2(NREG),
  localparam int RW   = (NRF > 1) ? $clog2(NRF) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_set_en,
  input  logic [RW-1:0]          i_set_rf,
  input  logic [AW-1:0]          i_set_ad,
  input  logic                   i_clr_en,
  input  logic [RW-1:0]          i_clr_rf,
  input  logic [AW-1:0]          i_clr_ad,
  input  logic [(NSRC+1)*RW-1:0] i_rd_rf,
  input  logic [(NSRC+1)*AW-1:0] i_rd_ad,
  output logic [NSRC:0]          o_q
);

  logic [NREG-1:0] r_sb [NRF];

  // Set is written last so a same-cycle set beats the clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int f = 0; f < NRF; f++)
        r_sb[f] <= '0;
    end else begin
      if (i_clr_en)
        r_sb[i_clr_rf][i_clr_ad] <= 1'b0;
      if (i_set_en)
        r_sb[i_set_rf][i_set_ad] <= 1'b1;
    end
  end

  always_comb begin
    o_q = '0;
    for (int i = 0; i <= NSRC; i++)
      o_q[i] = r_sb[i_rd_rf[i*RW +: RW]][i_rd_ad[i*AW +: AW]];
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-side hazard unit tracking one
// multi-cycle unit, load-use and branch flushes.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NREG   = 32,
  parameter  int NRF    = 2,
  parameter  int NSRC   = 3,
  parameter  int TMO_W  = 8,
  parameter  int PERF_W = 32,
  localparam int AW     = $clog2(NREG),
  localparam int RW     = (NRF > 1) ? $clog2(NRF) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NSRC-1:0]    src_vld_d,
  input  logic [NSRC*RW-1:0] src_rf_d,
  input  logic [NSRC*AW-1:0] src_ad_d,
  input  logic               dst_vld_d,
  input  logic [RW-1:0]      dst_rf_d,
  input  logic [AW-1:0]      dst_ad_d,
  input  logic               mc_req_d,
  input  logic               ld_e,
  input  logic [RW-1:0]      ld_rf_e,
  input  logic [AW-1:0]      ld_rd_e,
  input  logic               pcsrc_e,
  input  logic               mc_issue,
  input  logic [RW-1:0]      mc_issue_rf,
  input  logic [AW-1:0]      mc_issue_rd,
  input  logic               mc_done,
  output logic               stall_f,
  output logic               stall_d,
  output logic               flush_d,
  output logic               flush_e,
  output logic               mc_busy,
  output logic               mc_tmo,
  output logic [PERF_W-1:0]  stall_cnt
);

  mc_state_e         r_state, w_state_nxt;
  logic [TMO_W-1:0]  r_wd;
  logic [TMO_W-1:0]  w_wd_inc;
  logic              r_tmo;
  logic [PERF_W-1:0] r_cnt;
  logic [RW-1:0]     r_pend_rf;
  logic [AW-1:0]     r_pend_rd;

  logic          w_busy, w_issue_ok, w_done_ok, w_perr;
  logic          w_set_en;
  logic [NSRC:0] w_q;
  logic          w_raw, w_ldm, w_lduse, w_waw, w_strct, w_hz;

  assign w_busy     = (r_state == BUSY);
  assign w_issue_ok = mc_issue & (~w_busy | mc_done);
  assign w_done_ok  = mc_done & w_busy;
  assign w_perr     = mc_issue & w_busy & ~mc_done;
  assign w_set_en   = w_issue_ok &
                      ~is_x0(32'(mc_issue_rf), 32'(mc_issue_rd));
  assign w_wd_inc   = r_wd + 1'b1;

  sb_regfile #(
    .NREG (NREG),
    .NRF  (NRF),
    .NSRC (NSRC)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .i_set_en (w_set_en),
    .i_set_rf (mc_issue_rf),
    .i_set_ad (mc_issue_rd),
    .i_clr_en (w_done_ok),
    .i_clr_rf (r_pend_rf),
    .i_clr_ad (r_pend_rd),
    .i_rd_rf  ({dst_rf_d, src_rf_d}),
    .i_rd_ad  ({dst_ad_d, src_ad_d}),
    .o_q      (w_q)
  );

  always_comb begin
    w_raw = 1'b0;
    w_ldm = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_vld_d[i] && w_q[i])
        w_raw = 1'b1;
      if (src_vld_d[i] &&
          src_rf_d[i*RW +: RW] == ld_rf_e &&
          src_ad_d[i*AW +: AW] == ld_rd_e)
        w_ldm = 1'b1;
    end
  end

  assign w_lduse = ld_e & w_ldm &
                   ~is_x0(32'(ld_rf_e), 32'(ld_rd_e));
  assign w_waw   = dst_vld_d & w_q[NSRC];
  assign w_strct = mc_req_d & mc_busy & ~mc_done;
  assign w_hz    = w_raw | w_lduse | w_waw | w_strct;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (mc_issue) w_state_nxt = BUSY;
      BUSY: if (mc_done && !mc_issue) w_state_nxt = IDLE;
    endcase
  end

  // A resolved branch squashes the stalled insn, so it wins.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (rst) begin
      priority case (1'b1)
        pcsrc_e: begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end
        w_hz: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_wd      <= '0;
      r_tmo     <= 1'b0;
      r_cnt     <= '0;
      r_pend_rf <= '0;
      r_pend_rd <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue_ok) begin
        r_pend_rf <= mc_issue_rf;
        r_pend_rd <= mc_issue_rd;
        r_wd      <= '0;
      end else if (w_busy && !mc_done) begin
        if (!(&r_wd))
          r_wd <= w_wd_inc;
        if (&w_wd_inc)
          r_tmo <= 1'b1;
      end
      if (w_perr)
        r_tmo <= 1'b1;
      if (stall_d && !(&r_cnt))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign mc_busy   = rst & w_busy;
  assign mc_tmo    = r_tmo;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed cycles push expected outputs
// into a queue; a negedge monitor pops and compares them.
module tb_hazard_scoreboard;

  localparam int PW = 6;

  localparam logic [3:0] C_NONE  = 4'b0000;
  localparam logic [3:0] C_STALL = 4'b1101;
  localparam logic [3:0] C_BR    = 4'b0011;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    src_vld_d;
  logic [2:0]    src_rf_d;
  logic [14:0]   src_ad_d;
  logic          dst_vld_d;
  logic          dst_rf_d;
  logic [4:0]    dst_ad_d;
  logic          mc_req_d;
  logic          ld_e;
  logic          ld_rf_e;
  logic [4:0]    ld_rd_e;
  logic          pcsrc_e;
  logic          mc_issue;
  logic          mc_issue_rf;
  logic [4:0]    mc_issue_rd;
  logic          mc_done;
  logic          stall_f, stall_d, flush_d, flush_e;
  logic          mc_busy, mc_tmo;
  logic [PW-1:0] stall_cnt;

  typedef struct {
    string       nm;
    logic [11:0] v;
  } exp_t;

  exp_t          q[$];
  exp_t          m_e;
  logic [11:0]   m_got;
  logic [PW-1:0] m_cnt;
  int            n_err  = 0;
  int            n_chk  = 0;
  int            n_push = 0;

  hazard_scoreboard #(.PERF_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_vld_d   (src_vld_d),
    .src_rf_d    (src_rf_d),
    .src_ad_d    (src_ad_d),
    .dst_vld_d   (dst_vld_d),
    .dst_rf_d    (dst_rf_d),
    .dst_ad_d    (dst_ad_d),
    .mc_req_d    (mc_req_d),
    .ld_e        (ld_e),
    .ld_rf_e     (ld_rf_e),
    .ld_rd_e     (ld_rd_e),
    .pcsrc_e     (pcsrc_e),
    .mc_issue    (mc_issue),
    .mc_issue_rf (mc_issue_rf),
    .mc_issue_rd (mc_issue_rd),
    .mc_done     (mc_done),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .flush_e     (flush_e),
    .mc_busy     (mc_busy),
    .mc_tmo      (mc_tmo),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() != 0) begin
      m_e   = q.pop_front();
      m_got = {stall_f, stall_d, flush_d, flush_e,
               mc_busy, mc_tmo, stall_cnt};
      n_chk++;
      if (m_got !== m_e.v) begin
        n_err++;
        $display("FAIL %s: got sf,sd,fd,fe=%b busy=%b tmo=%b cnt=%0d, expected sf,sd,fd,fe=%b busy=%b tmo=%b cnt=%0d",
                 m_e.nm, m_got[11:8], m_got[7], m_got[6],
                 m_got[5:0], m_e.v[11:8], m_e.v[7], m_e.v[6],
                 m_e.v[5:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic idle_in();
    src_vld_d   = '0;
    src_rf_d    = '0;
    src_ad_d    = '0;
    dst_vld_d   = 1'b0;
    dst_rf_d    = 1'b0;
    dst_ad_d    = '0;
    mc_req_d    = 1'b0;
    ld_e        = 1'b0;
    ld_rf_e     = 1'b0;
    ld_rd_e     = '0;
    pcsrc_e     = 1'b0;
    mc_issue    = 1'b0;
    mc_issue_rf = 1'b0;
    mc_issue_rd = '0;
    mc_done     = 1'b0;
  endtask

  task automatic set_src(input int i, input logic rf,
                         input logic [4:0] ad);
    src_vld_d[i]       = 1'b1;
    src_rf_d[i]        = rf;
    src_ad_d[i*5 +: 5] = ad;
  endtask

  task automatic issue(input logic rf, input logic [4:0] rd);
    mc_issue    = 1'b1;
    mc_issue_rf = rf;
    mc_issue_rd = rd;
  endtask

  task automatic cyc(input string nm, input logic [3:0] c,
                     input logic b, input logic t);
    exp_t e;
    e.nm = nm;
    e.v  = {c, b, t, m_cnt};
    q.push_back(e);
    n_push++;
    @(posedge clk);
    #1;
    if (!rst)
      m_cnt = '0;
    else if (c[2] && m_cnt != '1)
      m_cnt = m_cnt + 1'b1;
    idle_in();
  endtask

  initial begin
    rst   = 1'b0;
    m_cnt = '0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    pcsrc_e = 1'b1;
    set_src(0, 1'b0, 5'd3);
    cyc("rst_force", C_NONE, 1'b0, 1'b0);
    rst = 1'b1;
    cyc("idle", C_NONE, 1'b0, 1'b0);

    issue(1'b1, 5'd0);
    cyc("fdiv_iss", C_NONE, 1'b0, 1'b0);
    set_src(0, 1'b1, 5'd0);
    cyc("raw_f0_a", C_STALL, 1'b1, 1'b0);
    set_src(0, 1'b1, 5'd0);
    cyc("raw_f0_b", C_STALL, 1'b1, 1'b0);
    set_src(0, 1'b1, 5'd0);
    mc_done = 1'b1;
    cyc("raw_f0_done", C_STALL, 1'b1, 1'b0);
    set_src(0, 1'b1, 5'd0);
    cyc("raw_f0_rel", C_NONE, 1'b0, 1'b0);

    ld_e = 1'b1;
    set_src(0, 1'b0, 5'd0);
    cyc("ld_x0", C_NONE, 1'b0, 1'b0);
    ld_e = 1'b1; ld_rf_e = 1'b1;
    set_src(0, 1'b1, 5'd0);
    cyc("ld_f0", C_STALL, 1'b0, 1'b0);
    ld_e = 1'b1; ld_rd_e = 5'd5;
    set_src(1, 1'b0, 5'd5);
    cyc("ld_x5", C_STALL, 1'b0, 1'b0);
    set_src(1, 1'b0, 5'd5);
    cyc("ld_x5_rel", C_NONE, 1'b0, 1'b0);
    ld_e = 1'b1; ld_rd_e = 5'd5;
    set_src(1, 1'b1, 5'd5);
    cyc("ld_x5_f5", C_NONE, 1'b0, 1'b0);

    issue(1'b0, 5'd7);
    cyc("div_x7", C_NONE, 1'b0, 1'b0);
    mc_req_d = 1'b1;
    cyc("strct", C_STALL, 1'b1, 1'b0);
    mc_req_d = 1'b1; mc_done = 1'b1;
    issue(1'b0, 5'd8);
    cyc("b2b", C_NONE, 1'b1, 1'b0);
    set_src(0, 1'b0, 5'd7);
    cyc("x7_clr", C_NONE, 1'b1, 1'b0);
    set_src(2, 1'b0, 5'd8);
    cyc("x8_set", C_STALL, 1'b1, 1'b0);
    dst_vld_d = 1'b1; dst_ad_d = 5'd8;
    cyc("waw_x8", C_STALL, 1'b1, 1'b0);
    dst_vld_d = 1'b1; dst_ad_d = 5'd9;
    cyc("waw_x9", C_NONE, 1'b1, 1'b0);
    set_src(2, 1'b0, 5'd8);
    pcsrc_e = 1'b1;
    cyc("br_wins", C_BR, 1'b1, 1'b0);
    mc_done = 1'b1;
    cyc("done_x8", C_NONE, 1'b1, 1'b0);

    issue(1'b0, 5'd0);
    cyc("iss_x0", C_NONE, 1'b0, 1'b0);
    set_src(0, 1'b0, 5'd0);
    mc_done = 1'b1;
    cyc("x0_untrk", C_NONE, 1'b1, 1'b0);

    issue(1'b0, 5'd3);
    cyc("wd_iss", C_NONE, 1'b0, 1'b0);
    for (int k = 0; k < 255; k++)
      cyc("wd_run", C_NONE, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      cyc("wd_tmo", C_NONE, 1'b1, 1'b1);

    rst = 1'b0;
    @(posedge clk);
    #1;
    m_cnt = '0;
    pcsrc_e = 1'b1;
    set_src(0, 1'b0, 5'd3);
    cyc("rst_mid", C_NONE, 1'b0, 1'b0);
    rst = 1'b1;
    set_src(0, 1'b0, 5'd3);
    cyc("post_rst", C_NONE, 1'b0, 1'b0);

    issue(1'b0, 5'd10);
    cyc("iss_x10", C_NONE, 1'b0, 1'b0);
    issue(1'b0, 5'd11);
    cyc("perr_iss", C_NONE, 1'b1, 1'b0);
    set_src(0, 1'b0, 5'd11);
    cyc("perr_x11", C_NONE, 1'b1, 1'b1);
    set_src(0, 1'b0, 5'd10);
    cyc("perr_x10", C_STALL, 1'b1, 1'b1);
    mc_done = 1'b1;
    cyc("done_x10", C_NONE, 1'b1, 1'b1);
    mc_done = 1'b1;
    cyc("done_idle", C_NONE, 1'b0, 1'b1);
    set_src(0, 1'b0, 5'd10);
    cyc("x10_clr", C_NONE, 1'b0, 1'b1);

    for (int k = 0; k < 70; k++) begin
      ld_e = 1'b1; ld_rd_e = 5'd5;
      set_src(0, 1'b0, 5'd5);
      cyc("sat", C_STALL, 1'b0, 1'b1);
    end
    cyc("sat_hold", C_NONE, 1'b0, 1'b1);

    n_chk++;
    if (q.size() != 0 || n_chk != n_push + 1) begin
      n_err++;
      $display("FAIL drain: got checks=%0d left=%0d, expected checks=%0d left=0",
               n_chk - 1, q.size(), n_push);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
